// File: rtl/exec_ctrl_pkg.sv
// exec_ctrl_pkg: shared opcodes, ALU codes, FSM states and psr bit indices
package exec_ctrl_pkg;
  localparam logic [3:0] OP_REG = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h5;
  localparam logic [3:0] OP_SUB = 4'h9;
  localparam logic [3:0] OP_AND = 4'h1;
  localparam logic [3:0] OP_OR  = 4'h2;
  localparam logic [3:0] OP_XOR = 4'h3;
  localparam logic [3:0] OP_CMP = 4'hB;
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b1000;
  localparam logic [3:0] ALU_AND = 4'b0001;
  localparam logic [3:0] ALU_OR  = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam int PSR_C = 0;
  localparam int PSR_L = 1;
  localparam int PSR_O = 2;
  localparam int PSR_E = 3;
  localparam int PSR_N = 4;
  typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, WRITEBACK, PARK} state_t;
endpackage

// File: rtl/instr_decode.sv
// instr_decode: maps an instruction word to ALU controls and writeback enables
module instr_decode
  import exec_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [15:0]      instr,
  output logic [3:0]       alu_inst,
  output logic             imm_sel,
  output logic [WIDTH-1:0] imm_val,
  output logic             writes_rf,
  output logic             writes_psr,
  output logic             illegal
);
  logic [3:0] fn;
  logic       reg_form, known, arith;
  assign reg_form   = instr[15:12] == OP_REG;
  assign fn         = reg_form ? instr[7:4] : instr[15:12];
  assign known      = fn inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_CMP};
  assign arith      = fn inside {OP_ADD, OP_SUB, OP_CMP};
  assign alu_inst   = !known ? ALU_ADD :
                      fn == OP_ADD ? ALU_ADD :
                      arith ? ALU_SUB :
                      fn == OP_AND ? ALU_AND :
                      fn == OP_OR ? ALU_OR : ALU_XOR;
  assign imm_sel    = known && !reg_form;
  assign imm_val    = !imm_sel ? '0 : arith ? WIDTH'($signed(instr[7:0])) : WIDTH'(instr[7:0]);
  assign writes_rf  = known && fn != OP_CMP;
  assign writes_psr = known && arith;
  assign illegal    = !known;
endmodule

// File: rtl/exec_ctrl.sv
// exec_ctrl: four-cycle fetch/decode/execute/writeback controller with park support
module exec_ctrl
  import exec_ctrl_pkg::*;
#(
  parameter int               WIDTH    = 16,
  parameter logic [WIDTH-1:0] PC_RESET = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [15:0]      instr,
  input  logic             instr_valid,
  input  logic             hold,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [4:0]       alu_flags,
  output logic             fetch_req,
  output logic [WIDTH-1:0] pc,
  output logic [3:0]       rsrc,
  output logic [3:0]       rdst,
  output logic [3:0]       alu_inst,
  output logic             imm_sel,
  output logic [WIDTH-1:0] imm_val,
  output logic             rf_we,
  output logic [3:0]       rf_waddr,
  output logic [WIDTH-1:0] rf_wdata,
  output logic [4:0]       psr,
  output logic             illegal
);
  state_t           state;
  logic [15:0]      ir;
  logic             fq, wq;
  logic [3:0]       d_alu_inst;
  logic             d_imm_sel, d_writes_rf, d_writes_psr, d_illegal;
  logic [WIDTH-1:0] d_imm_val;
  instr_decode #(.WIDTH(WIDTH)) u_dec (
    .instr      (ir),
    .alu_inst   (d_alu_inst),
    .imm_sel    (d_imm_sel),
    .imm_val    (d_imm_val),
    .writes_rf  (d_writes_rf),
    .writes_psr (d_writes_psr),
    .illegal    (d_illegal)
  );
  assign fetch_req = fq && reset_n;
  assign rf_we     = wq && reset_n;
  assign rf_wdata  = alu_result;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= FETCH;
      pc       <= PC_RESET;
      psr      <= '0;
      illegal  <= 1'b0;
      ir       <= '0;
      fq       <= 1'b0;
      wq       <= 1'b0;
      rf_waddr <= '0;
      rsrc     <= '0;
      rdst     <= '0;
      alu_inst <= '0;
      imm_sel  <= 1'b0;
      imm_val  <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (fq && instr_valid) begin
            ir    <= instr;
            rdst  <= instr[11:8];
            rsrc  <= instr[3:0];
            fq    <= 1'b0;
            state <= DECODE;
          end else fq <= 1'b1;
        end
        DECODE: begin
          alu_inst <= d_alu_inst;
          imm_sel  <= d_imm_sel;
          imm_val  <= d_imm_val;
          state    <= EXECUTE;
        end
        EXECUTE: begin
          wq       <= d_writes_rf;
          rf_waddr <= ir[11:8];
          state    <= WRITEBACK;
        end
        WRITEBACK: begin
          wq    <= 1'b0;
          pc    <= pc + WIDTH'(1);
          psr   <= d_writes_psr ? alu_flags : psr;
          illegal <= illegal || d_illegal;
          fq    <= !hold;
          state <= hold ? PARK : FETCH;
        end
        PARK: begin
          fq    <= !hold;
          state <= hold ? PARK : FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end
endmodule
